adc_scan_sequencer: RTL

Multi-channel scan scheduler sitting above `adc_controller`. It owns the controller's active-low enable and an external analog mux select. It visits enabled channels round-robin and collects 2^AVG_LOG2 conversions per channel. For each channel it emits one averaged WIDTH-bit result with its channel tag. Host control is a single active-low level enable, consistent with the controller's `en_` convention.

---
 rtl/adc_scan_pkg.sv | 27 ++
 rtl/adc_ch_picker.sv | 51 +++++
 rtl/adc_scan_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_scan_pkg                                                         |
// | Shared state encoding and width helpers for the ADC scan sequencer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adc_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_REPORT = 3'd4
  } scan_state_e;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

  // One spare bit above WIDTH+AVG_LOG2 absorbs the rounding offset.
  function automatic int acc_w(input int width, input int avg_log2);
    return width + avg_log2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_ch_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_ch_picker                                                        |
// | Round-robin channel pick: lowest enabled channel at/above the        |
// | pointer, else lowest enabled overall; flags the top enabled channel. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_ch_picker
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   ch_o,
  output logic              found_o,
  output logic              last_o
);

  logic [CH_W-1:0] lo_ch;
  logic [CH_W-1:0] hi_ch;
  logic            hi_found;

  always_comb begin
    lo_ch    = '0;
    hi_ch    = '0;
    hi_found = 1'b0;
    found_o  = 1'b0;
    // Descending scan so the last hit is the lowest index.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        found_o = 1'b1;
        lo_ch   = CH_W'(i);
        if (CH_W'(i) >= ptr_i) begin
          hi_found = 1'b1;
          hi_ch    = CH_W'(i);
        end
      end
    end
    ch_o   = hi_found ? hi_ch : lo_ch;
    last_o = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask_i[i] && (CH_W'(i) > ch_o)) begin
        last_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_scan_sequencer                                                   |
// | Round-robin multi-channel scan with per-channel averaging above      |
// | adc_controller. Optional macro ADC_SCAN_ROUND_EN: round-half-up with |
// | saturation instead of truncation.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int WIDTH         = 12,
  parameter int NUM_CH        = 4,
  parameter int AVG_LOG2      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset_,
  input  logic                        en_,
  input  logic [NUM_CH-1:0]           ch_mask,
  input  logic                        adc_ack,
  input  logic [WIDTH-1:0]            adc_data,
  output logic                        adc_en_,
  output logic [ch_idx_w(NUM_CH)-1:0] ch_sel,
  output logic [WIDTH-1:0]            result,
  output logic [ch_idx_w(NUM_CH)-1:0] result_ch,
  output logic                        result_valid,
  output logic                        scan_done,
  output logic                        busy
);

  localparam int CH_W  = ch_idx_w(NUM_CH);
  localparam int ACC_W = acc_w(WIDTH, AVG_LOG2);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(NUM_CH - 1);

  scan_state_e      state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]  result_ch_q, result_ch_d;
  logic             last_q, last_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             adc_en_q, adc_en_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [ACC_W-1:0] acc_sum;
  logic [WIDTH-1:0] avg;
  logic [CH_W-1:0]  pick;
  logic             pick_found;
  logic             pick_last;

  adc_ch_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .mask_i  (ch_mask),
    .ptr_i   (ptr_q),
    .ch_o    (pick),
    .found_o (pick_found),
    .last_o  (pick_last)
  );

  // The average is taken from the sum including the final sample so the
  // result is registered on the very edge that consumes the last ack.
  assign acc_sum = acc_q + ACC_W'(adc_data);

`ifdef ADC_SCAN_ROUND_EN
  logic [ACC_W-1:0] rnd_sum;
  logic [WIDTH:0]   rnd_avg;
  logic             unused_rnd;
  if (AVG_LOG2 > 0) begin : g_round_ofs
    assign rnd_sum = acc_sum + ACC_W'(1 << (AVG_LOG2 - 1));
  end else begin : g_round_none
    assign rnd_sum = acc_sum;
  end
  assign rnd_avg    = rnd_sum[AVG_LOG2 +: WIDTH+1];
  assign avg        = rnd_avg[WIDTH] ? {WIDTH{1'b1}} : rnd_avg[WIDTH-1:0];
  assign unused_rnd = ^rnd_sum;
`else
  assign avg = acc_sum[AVG_LOG2 +: WIDTH];
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ch_sel_d    = ch_sel_q;
    result_ch_d = result_ch_q;
    last_d      = last_q;
    settle_d    = settle_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    result_d    = result_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ptr_d = '0;
        if (!en_ && (|ch_mask)) begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick_found) begin
          ch_sel_d = pick;
          ptr_d    = (pick == CH_MAX) ? '0 : pick + 1'b1;
          last_d   = pick_last;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_LAST) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_ACCUM: begin
        if (adc_ack) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d    = avg;
            result_ch_d = ch_sel_q;
            valid_d     = 1'b1;
            done_d      = last_q;
            state_d     = ST_REPORT;
          end
        end
      end
      ST_REPORT: begin
        state_d = en_ ? ST_IDLE : ST_SELECT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort overrides everything, including a report due on this edge.
    if (en_ && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      result_d    = result_q;
      result_ch_d = result_ch_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;
    end
    adc_en_d = (state_d != ST_ACCUM);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      ch_sel_q    <= '0;
      result_ch_q <= '0;
      last_q      <= 1'b0;
      settle_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      adc_en_q    <= 1'b1;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ch_sel_q    <= ch_sel_d;
      result_ch_q <= result_ch_d;
      last_q      <= last_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      adc_en_q    <= adc_en_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign adc_en_      = adc_en_q;
  assign ch_sel       = ch_sel_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = valid_q;
  assign scan_done    = done_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
